// File: rtl/c17_bist_pkg.sv
// Shared types and helpers for the c17 BIST controller.
// MISR step function is common to the RTL and its reference model.
package c17_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CMP,
    DONE
  } state_t;

  localparam logic [7:0] SIG_POLY_DEF = 8'h1D;
  localparam logic [7:0] SIG_SEED_DEF = 8'hFF;

  // Generic-width MISR step; w is the register width (<= 32).
  function automatic logic [31:0] misr_next(
    input logic [31:0] sig,
    input logic [31:0] resp,
    input logic [31:0] poly,
    input int unsigned w
  );
    logic [31:0] m;
    logic        msb;
    m   = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    msb = ((sig >> (w - 1)) & 32'd1) != 32'd0;
    return ({sig[30:0], 1'b0} ^ (msb ? poly : 32'd0) ^ resp) & m;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register compacting the CUT response.
// Seed load takes priority over a compaction step.
module bist_misr
  import c17_bist_pkg::*;
#(
  parameter int               SIG_W    = 8,
  parameter int               RSP_W    = 2,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_POLY_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [SIG_W-1:0] seed,
  input  logic             en,
  input  logic [RSP_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_nxt;

  assign w_nxt = SIG_W'(misr_next(
    32'(r_sig), 32'(din), 32'(SIG_POLY), SIG_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (load) begin
      r_sig <= seed;
    end else if (en) begin
      r_sig <= w_nxt;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST controller: exhaustive pattern source, MISR compaction
// and golden-signature compare for the c17 netlist.
module c17_bist_ctrl
  import c17_bist_pkg::*;
#(
  parameter int               PAT_W      = 5,
  parameter int               RSP_W      = 2,
  parameter int               SIG_W      = 8,
  parameter logic [SIG_W-1:0] SIG_POLY   = SIG_POLY_DEF,
  parameter logic [SIG_W-1:0] SIG_SEED   = SIG_SEED_DEF,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [RSP_W-1:0] resp_i,
  output logic [PAT_W-1:0] pat_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [SIG_W-1:0] sig_o
);

  localparam int CNT_W = PAT_W + 1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last;
  logic             w_go;
  logic             w_load;
  logic             w_en;
  logic [SIG_W-1:0] w_sig;

  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  // Extra counter bit flags the terminal count without aliasing.
  assign w_last    = w_cnt_nxt[PAT_W];
  assign w_go      = start_i & ~abort_i;
  assign w_load    = w_go & ((r_state == IDLE) | (r_state == DONE));
  assign w_en      = (r_state == RUN) & ~abort_i;

  bist_misr #(
    .SIG_W   (SIG_W),
    .RSP_W   (RSP_W),
    .SIG_POLY(SIG_POLY)
  ) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (w_load),
    .seed (SIG_SEED),
    .en   (w_en),
    .din  (resp_i),
    .sig  (w_sig)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_go) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (abort_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (w_last) begin
            r_state <= CMP;
            r_cnt   <= '0;
          end else begin
            r_cnt   <= w_cnt_nxt;
          end
        end
        CMP: begin
          r_busy <= 1'b0;
          r_cnt  <= '0;
          if (abort_i) begin
            r_state <= IDLE;
          end else begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_pass  <= (w_sig == GOLDEN_SIG);
          end
        end
        DONE: begin
          if (abort_i) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end else if (start_i) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign pat_o  = r_cnt[PAT_W-1:0];
  assign busy_o = r_busy;
  assign done_o = r_done;
  assign pass_o = r_pass;
  assign sig_o  = w_sig;

endmodule

// File: doc/c17_bist_ctrl.md
Name: c17_bist_ctrl

Overview:
- Built-in self-test controller that drives the c17 NAND benchmark netlist from the tester side.
- Generates an exhaustive 5-bit input pattern sequence for the circuit under test (CUT) and compacts the 2-bit CUT response into a signature register (MISR).
- Compares the final signature against a golden value and reports pass/fail.
- Sits beside the combinational CUT: drives its inputs N1,N2,N3,N6,N7 and samples its outputs N22,N23.

Parameters:
- PAT_W, 5, CUT input width; pattern count N = 2^PAT_W.
- RSP_W, 2, CUT output width.
- SIG_W, 8, MISR width; must be > RSP_W.
- SIG_POLY, 8'h1D, MISR feedback taps (x^8+x^4+x^3+x^2+1).
- SIG_SEED, 8'hFF, MISR value loaded on start.
- GOLDEN_SIG, 8'h00, expected final signature; set per instance from the bench reference model.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle request to begin a test; honoured only in IDLE or DONE.
- abort_i  in  1  cancels a test in progress; wins over start_i.
- resp_i  in  RSP_W  CUT outputs {N23,N22}.
- pat_o  out  PAT_W  registered CUT inputs {N7,N6,N3,N2,N1}.
- busy_o  out  1  high in RUN and CMP.
- done_o  out  1  high in DONE.
- pass_o  out  1  valid while done_o=1; 0 otherwise.
- sig_o  out  SIG_W  current MISR contents.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; pat_o=0, busy_o=0, done_o=0, pass_o=0.
  - sig_o=0, not SIG_SEED.
- FSM states: IDLE, RUN, CMP, DONE.
- IDLE:
  - start_i=1 & abort_i=0 -> RUN; load pat_o=0 and MISR=SIG_SEED.
- RUN:
  - pat_o=k is held for exactly one cycle, with k=0..N-1 in binary order.
  - At the edge that ends the cycle holding pattern k, MISR absorbs resp_i, so the CUT gets a full cycle to settle.
  - On that same edge, pat_o increments.
  - After absorbing pattern N-1, the next state is CMP and pat_o wraps to 0.
- MISR update:
  - sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : 0) ^ zero-extended resp_i.
  - resp_i bit0 is XORed into sig bit0 and resp_i bit1 into sig bit1.
  - The MISR is updated only in RUN; it holds in every other state.
- CMP:
  - One cycle; registers pass = (sig == GOLDEN_SIG); next state is DONE.
- DONE:
  - done_o=1; pass_o and sig_o are held.
  - start_i -> RUN, with a fresh seed and pass_o cleared.
  - abort_i -> IDLE, with done_o and pass_o cleared.
- Latency (start_i sampled at edge E0):
  - busy_o is high from E0 to E0+N+1.
  - done_o rises at edge E0+N+1, i.e. 34 edges for N=32.
- Boundary and simultaneous events:
  - start_i during RUN or CMP: ignored.
  - abort_i in RUN or CMP: next state IDLE; pat_o=0, busy_o=0; sig_o is held for debug.
  - start_i & abort_i in the same cycle: abort_i wins (IDLE); there is no restart that cycle.
  - rst_n low mid-run: immediate return to reset values, with no glitch-free requirement on pat_o.
  - Pattern counter width is PAT_W+1 internally so that the terminal count is detected without aliasing.

Decomposition:
- Shared package c17_bist_pkg holds:
  - state enum {IDLE,RUN,CMP,DONE};
  - the default SIG_POLY and SIG_SEED constants;
  - a function misr_next(sig, resp) used by both the RTL and the bench reference model.
- One sub-module: bist_misr (SIG_W, SIG_POLY; ports clk, rst_n, load, seed, en, din, sig).
- The pattern counter and FSM stay in the top.

Test Plan:
- Reset: assert rst_n=0 mid-cycle.
  - Required: all outputs 0 asynchronously, before the next clk edge.
- Golden run: bench c17 model wired to pat_o/resp_i; GOLDEN_SIG = signature from the package model; pulse start_i.
  - Required: pat_o steps 0..31 on consecutive cycles.
  - Required: done_o=1 at edge 34, pass_o=1, sig_o=GOLDEN_SIG.
- Fault detection: same run with N22 stuck-at-0 injected in the bench CUT.
  - Required: done_o at edge 34, pass_o=0, sig_o≠GOLDEN_SIG.
  - Repeat with GOLDEN_SIG^8'h01 on the fault-free CUT -> pass_o=0.
- Abort: start, then abort_i at pat_o=10.
  - Required: next cycle state IDLE, busy_o=0, pat_o=0, done_o=0, sig_o frozen.
  - A following start gives a full 32-pattern run with pass_o=1.
- Ignored start and priority:
  - start_i pulses at pat_o=5 and in the CMP cycle -> run timing unchanged (done at edge 34).
  - start_i & abort_i together in DONE -> IDLE, pass_o=0.
- Back-to-back: start_i in DONE.
  - Required: done_o drops next cycle, MISR reseeds to 8'hFF, second run produces an identical sig_o and pass_o=1.
